// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiply/divide unit that borrows a shared external ALU.
// One result every 33 cycles: 32 shift-add or shift-subtract iterations plus a done cycle.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_r,
  input  logic        alu_cf,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] copy_q, copy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;

  logic        sh_m;
  logic [31:0] sh_hi;
  logic [31:0] sh_lo;
  logic [31:0] fin;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    copy_d   = copy_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_sel  = AluAdd;
    busy     = 1'b0;
    done     = 1'b0;
    result   = result_q;

    // Divide step works on the pair shifted left by one; sh_m is the bit shifted out.
    {sh_m, sh_hi, sh_lo} = {hi_q, lo_q, 1'b0};
    // MULHU and REMU live in hi, MUL and DIVU in lo.
    fin = op_q[0] ? hi_q : lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          op_d    = op;
          hi_d    = 32'd0;
          cnt_d   = 5'd0;
          if (op[1]) begin
            lo_d   = src_a;
            copy_d = src_b;
          end else begin
            lo_d   = src_b;
            copy_d = src_a;
          end
        end
      end
      StCalc: begin
        busy  = 1'b1;
        alu_b = copy_q;
        if (op_q[1]) begin
          alu_a   = sh_hi;
          alu_sel = AluSub;
          if (sh_m || alu_cf) begin
            hi_d = alu_r;
            lo_d = {sh_lo[31:1], 1'b1};
          end else begin
            hi_d = sh_hi;
            lo_d = sh_lo;
          end
        end else begin
          alu_a = hi_q;
          if (lo_q[0]) begin
            hi_d = {alu_cf, alu_r[31:1]};
            lo_d = {alu_r[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end
      end
      StDone: begin
        busy    = 1'b1;
        state_d = StIdle;
        // A flush in the done cycle suppresses the pulse and leaves the held result alone.
        if (!flush) begin
          done     = 1'b1;
          result   = fin;
          result_d = fin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      copy_q   <= 32'd0;
      cnt_q    <= 5'd0;
      op_q     <= 2'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      copy_q   <= copy_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: behavioural shared ALU plus an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_r;
  logic        alu_cf;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int errors;
  logic [31:0] last_res;

  muldiv_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_r   (alu_r),
    .alu_cf  (alu_cf),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add, or subtract with carry meaning a >= b.
  always_comb begin
    if (alu_sel == 4'b0001) begin
      alu_r  = alu_a - alu_b;
      alu_cf = (alu_a >= alu_b);
    end else begin
      {alu_cf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
    end
  end

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issues one operation; optionally pulses a stray start in cycle inj. Returns the result seen
  // with done, the cycle (relative to the accepting edge) it appeared in, and whether busy held.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output logic [31:0] res, output int lat,
                        output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    lat     = 0;
    busy_ok = 1'b1;
    res     = 32'hxxxx_xxxx;
    for (int c = 1; c <= 40; c++) begin
      start = (c == inj);
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        res = result;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, result, alu_a, alu_b, alu_sel} !== 102'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h alu_a=%h alu_b=%h sel=%h want 0",
               busy, done, result, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_mul_timing;
    bit ok_busy;
    bit ok_done;
    ok_busy = 1'b1;
    ok_done = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0; src_a = 32'd99; src_b = 32'd99;
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd7 || alu_sel !== 4'b0000) begin
      errors++;
      $display("FAIL mul_first_iter_alu: a=%h b=%h sel=%h want 0/7/0", alu_a, alu_b, alu_sel);
    end
    for (int c = 1; c <= 34; c++) begin
      if (busy !== (c <= 33)) ok_busy = 1'b0;
      if (done !== (c == 33)) ok_done = 1'b0;
      if (c == 33) begin
        checks++;
        if (result !== 32'd42) begin
          errors++;
          $display("FAIL mul_7x6_result: got %0d want 42", result);
        end
      end
      if (c < 34) @(negedge clk);
    end
    checks++;
    if (!ok_busy) begin
      errors++;
      $display("FAIL mul_busy_window: busy not high exactly in cycles 1..33");
    end
    checks++;
    if (!ok_done) begin
      errors++;
      $display("FAIL mul_done_window: done not high exactly in cycle 33");
    end
    checks++;
    if (result !== 32'd42 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL idle_after_done: result=%h alu_a=%h alu_b=%h want 2a/0/0",
               result, alu_a, alu_b);
    end
    last_res = 32'd42;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000,
                             32'd5, 32'd5, 32'd0};
    logic [31:0] bs  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0,
                             32'h1234_5678};
    logic [31:0] want[8] = '{32'hFFFF_FFFE, 32'h1, 32'd14, 32'd2, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'd5, 32'd0};
    logic [31:0] res;
    int lat;
    bit bok;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 0, res, lat, bok);
      checks++;
      if (res !== want[i] || lat != 33 || !bok) begin
        errors++;
        $display("FAIL directed_%0d op=%0d a=%h b=%h: got %h lat=%0d busy_ok=%0b want %h lat=33",
                 i, ops[i], as[i], bs[i], res, lat, bok, want[i]);
      end
      last_res = want[i];
    end
  endtask

  task automatic test_div_alu;
    @(negedge clk);
    start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (alu_sel !== 4'b0001 || alu_b !== 32'd7 || alu_a !== 32'd0) begin
      errors++;
      $display("FAIL div_first_iter_alu: a=%h b=%h sel=%h want 0/7/1", alu_a, alu_b, alu_sel);
    end
    repeat (33) @(negedge clk);
    last_res = 32'd14;
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, res, exp_r;
    int lat;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(3))
        0:       b = 32'($urandom_range(15));
        1:       b = a >> $urandom_range(31);
        default: b = $urandom;
      endcase
      exp_r = ref_model(o, a, b);
      run_op(o, a, b, 0, res, lat, bok);
      checks++;
      if (res !== exp_r || lat != 33 || !bok) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d want %h lat=33",
                 i, o, a, b, res, lat, exp_r);
      end
      last_res = exp_r;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    bit bok;
    run_op(2'd0, 32'd11, 32'd13, 0, res, lat, bok);
    // A start driven in the done cycle must be dropped.
    start = 1'b1; op = 2'd0; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_ignored: busy=%b want 0", busy);
    end
    run_op(2'd3, 32'd1000, 32'd33, 0, res, lat, bok);
    run_op(2'd2, 32'd1000, 32'd33, 0, res, lat, bok);
    checks++;
    if (res !== 32'd30 || lat != 33) begin
      errors++;
      $display("FAIL back_to_back: got %0d lat=%0d want 30 lat=33", res, lat);
    end
    last_res = 32'd30;
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int lat;
    bit bok;
    bit saw_done;
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'd123; src_b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
      errors++;
      $display("FAIL flush_calc: busy=%b done=%b result=%h want 0/0/%h",
               busy, done, result, last_res);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL flush_no_done: unit became busy or signalled done after flush");
    end
    // Flush with start in IDLE: start wins.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'd1; src_a = 32'h8000_0000; src_b = 32'd4;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_start_idle: busy=%b want 1", busy);
    end
    repeat (33) @(negedge clk);
    checks++;
    if (result !== 32'd2) begin
      errors++;
      $display("FAIL flush_start_result: got %h want 2", result);
    end
    run_op(2'd2, 32'd90, 32'd9, 21, res, lat, bok);
    checks++;
    if (res !== 32'd10 || lat != 33) begin
      errors++;
      $display("FAIL start_while_busy: got %0d lat=%0d want 10 lat=33", res, lat);
    end
    last_res = 32'd10;
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int lat;
    bit bok;
    @(negedge clk);
    start = 1'b1; op = 2'd3; src_a = 32'd777; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0; flush = 1'b1; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, result, alu_a, alu_b, alu_sel} !== 102'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%b done=%b result=%h alu_a=%h alu_b=%h sel=%h want 0",
               busy, done, result, alu_a, alu_b, alu_sel);
    end
    run_op(2'd0, 32'd3, 32'd3, 0, res, lat, bok);
    checks++;
    if (res !== 32'd9 || lat != 33 || !bok) begin
      errors++;
      $display("FAIL mul_after_reset: got %0d lat=%0d want 9 lat=33", res, lat);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    test_reset();
    test_mul_timing();
    test_directed();
    test_div_alu();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 No parameters; all datapath widths fixed at 32 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MUL (low 32), 01 MULHU (high 32), 10 DIVU, 11 REMU; all unsigned.
REQ-006 src_a, src_b  input  32 each  multiplicand/dividend, multiplier/divisor; captured with start.
REQ-007 flush  input  1  abort current operation.
REQ-008 alu_a, alu_b  output  32 each  shared-ALU operands.
REQ-009 alu_sel  output  4  shared-ALU function select: 0000 add, 0001 subtract.
REQ-010 alu_r  input  32  shared-ALU result.
REQ-011 alu_cf  input  1  shared-ALU carry out; for subtract, 1 means alu_a >= alu_b unsigned.
REQ-012 busy  output  1  high in CALC and DONE; pipeline stall request.
REQ-013 done  output  1  one-cycle result-valid pulse.
REQ-014 result  output  32  operation result.

Function
REQ-015 FSM states: IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-016 Internal regs: 32-bit hi, 32-bit lo, 32-bit operand copy, 5-bit iteration counter, latched op.
REQ-017 start accepted at edge k; CALC occupies cycles k+1..k+32; done=1 and result valid in cycle k+33; IDLE in k+34.
REQ-018 start while busy ignored; start in DONE cycle ignored.
REQ-019 Back-to-back: start in the first IDLE cycle after DONE is accepted normally.
REQ-020 MUL/MULHU capture: hi=0, lo=src_b (multiplier), copy=src_a.
REQ-021 Multiply iteration: alu_a=hi, alu_b=copy, alu_sel=0000; if lo[0]: {c,hi,lo} = {alu_cf,alu_r,lo}>>1, else {hi,lo} = {0,hi,lo}>>1.
REQ-022 DIVU/REMU capture: hi=0, lo=src_a (dividend), copy=src_b (divisor).
REQ-023 Divide iteration: shifted {m,hi',lo'} = {hi,lo}<<1; alu_a=hi', alu_b=copy, alu_sel=0001; if m or alu_cf: hi=alu_r, lo=lo' with bit0=1; else hi=hi', lo=lo' with bit0=0.
REQ-024 In CALC, alu_a/alu_b/alu_sel are combinational from current regs; ALU result consumed same cycle.
REQ-025 result in DONE: MUL lo, MULHU hi, DIVU lo, REMU hi; result register holds value until next accepted start.
REQ-026 Divisor zero: no special path; DIVU yields 0xFFFFFFFF, REMU yields dividend (RISC-V semantics), same 33-cycle latency.
REQ-027 In IDLE and DONE: alu_a=0, alu_b=0, alu_sel=0000.
REQ-028 flush in CALC or DONE: state IDLE next cycle, done not asserted, result unchanged; flush in IDLE ignored.
REQ-029 flush and start in same IDLE cycle: start accepted.
REQ-030 Iteration counter wraps 31->0 exactly on CALC->DONE transition.

Reset
REQ-031 rst_n=0 at an edge: state IDLE, busy=0, done=0, result=0, hi=lo=copy=0, counter=0, ALU outputs per REQ-027.
REQ-032 Reset mid-operation aborts without done pulse; reset has priority over flush and start.

Verification
REQ-033 MUL 7*6: start at cycle 0 -> busy cycles 1..33, done=1 with result=42 in cycle 33 only.
REQ-034 MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-035 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; latency 33 cycles.
REQ-037 flush at CALC iteration 10 -> IDLE next cycle, no done, result keeps prior value; start pulsed at iteration 20 of a later operation ignored.
REQ-038 rst_n=0 during CALC iteration 15 -> all outputs at reset values next cycle; subsequent MUL 3*3 -> 9 with normal latency.
